dfd_tnif_arb: RTL and testbench
===============================

# dfd_tnif_arb

Two-source arbiter and output stage for the trace network interface (TNIF). Sits between the N-trace encoder (NTR) and debug-signal-trace (DST) producers and the single 16-byte TNIF output. Grants whole messages, never interleaving beats from the two sources. Alternates ownership when both contend and registers the winning beat onto the TNIF. Owner encoding is `dfd_tn_pkg::tnifState_e` (NTR_GNT=0, DST_GNT=1).

## Interface
Parameters:
- DATA_W, `dfd_tn_pkg::TNIF_DATA_OUT_WIDTH_IN_BYTES*8` (=128): beat width.
- CNT_W, 32: width of the per-source beat counters.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_ntr_en  in  1  NTR source enable, sampled only at arbitration.
- cfg_dst_en  in  1  DST source enable, sampled only at arbitration.
- ntr_valid  in  1  NTR beat valid.
- ntr_data  in  DATA_W  NTR beat data.
- ntr_last  in  1  final beat of the NTR message.
- ntr_ready  out  1  NTR beat accepted this cycle when high with ntr_valid.
- dst_valid  in  1  DST beat valid.
- dst_data  in  DATA_W  DST beat data.
- dst_last  in  1  final beat of the DST message.
- dst_ready  out  1  DST beat accepted this cycle when high with dst_valid.
- tnif_valid  out  1  output beat valid (registered).
- tnif_data  out  DATA_W  output beat data (registered).
- tnif_last  out  1  output end of message (registered).
- tnif_src  out  tnifState_e  source of the output beat (registered).
- tnif_ready  in  1  downstream accept.
- gnt_state  out  tnifState_e  owner of the most recently accepted beat.
- gnt_locked  out  1  a message is in progress; ownership frozen.
- cnt_clr  in  1  synchronous clear of both beat counters.
- ntr_beat_cnt  out  CNT_W  accepted NTR beats, saturating.
- dst_beat_cnt  out  CNT_W  accepted DST beats, saturating.

## Operation
- Output stage: one register (valid/data/last/src). `take = !tnif_valid | tnif_ready`. A new beat loads when an input beat is accepted. Otherwise, when `tnif_ready` is high, tnif_valid clears.
- Arbitration when gnt_locked=0:
  - Candidates are sources with valid=1 and enable=1.
  - Exactly one candidate: grant it.
  - Both candidates: grant the source opposite gnt_state (alternation).
  - No candidate: no grant; both readies are 0.
- Arbitration when gnt_locked=1: grant = gnt_state. Enables and the other source's valid are ignored.
- Ready and accept:
  - `x_ready = (grant==x) & take`.
  - Accept = `x_valid & x_ready`.
  - ready may depend on valid through arbitration. Producers must not make valid depend on ready.
- On accept:
  - gnt_state <= source.
  - gnt_locked <= !last.
  - The source counter increments.
- A single-beat message (last on first beat) leaves gnt_locked=0.
- Disabling a source while it holds the lock does not abort the message. The enable takes effect at the next arbitration.
- Counters:
  - Saturate at all-ones and hold.
  - cnt_clr wins over a same-cycle increment; the counter reads 0 next cycle.
- Reset values:
  - tnif_valid=0, tnif_data=0, tnif_last=0, tnif_src=NTR_GNT.
  - gnt_state=DST_GNT, so the first tie goes to NTR.
  - gnt_locked=0, both counters=0.
  - ntr_ready=dst_ready=0 while reset_n is low.
- Reset mid-message discards the in-flight beat and the lock. Producers are also reset.

## Timing
- Latency: input accept in cycle N → tnif_valid=1 with that beat in cycle N+1.
- Throughput: 1 beat/cycle sustained while tnif_ready=1, including across message boundaries.
  - Example: NTR last beat in cycle N, DST first beat in cycle N+1.
- Backpressure:
  - tnif_ready=0 with tnif_valid=1 forces both readies to 0.
  - Output register contents hold stable until tnif_ready=1.
- Grant decision is combinational in the cycle of acceptance. gnt_state/gnt_locked update at the clock edge after accept.
- Counters update the cycle after accept.

## Test plan
- Single source: NTR sends a 4-beat message (last on beat 4), DST idle, tnif_ready=1.
  - Required: tnif shows 4 beats in cycles 2–5 with tnif_src=NTR_GNT and tnif_last only on beat 4.
  - Required: ntr_beat_cnt=4; gnt_locked goes 1 after beat 1 and 0 after beat 4.
- Contention after reset: both sources present 2-beat messages continuously.
  - Required order: NTR, NTR, DST, DST, NTR, ...
  - Required: no interleaving within a message; one beat every cycle.
- Lock hold: during beat 2 of a 3-beat DST message, NTR asserts valid and cfg_dst_en drops.
  - Required: DST completes beat 3; NTR is granted the next cycle.
  - Required: further DST requests are ignored.
- Backpressure: tnif_ready=0 for 3 cycles mid-message.
  - Required: tnif_data stable and both readies 0 throughout; resumes without loss or duplication.
- Counters: preload a counter near saturation with CNT_W=4.
  - Required: ntr_beat_cnt stops at 15.
  - Required: cnt_clr in the same cycle as an accept gives 0 next cycle.
- Async reset asserted mid-message.
  - Required: tnif_valid=0, gnt_locked=0, gnt_state=DST_GNT immediately.
  - Required: after release, the first tie goes to NTR.

Source files
------------

// File: rtl/dfd_tnif_arb_if.sv
// Shared TNIF types and the beat handshake bundle between the trace producers,
// the arbiter and the TNIF output.
package dfd_tn_pkg;
   localparam int TNIF_DATA_OUT_WIDTH_IN_BYTES = 16;
   typedef enum logic {NTR_GNT = 1'b0, DST_GNT = 1'b1} tnifState_e;
endpackage

interface dfd_tnif_arb_if #(
   parameter int DATA_W = dfd_tn_pkg::TNIF_DATA_OUT_WIDTH_IN_BYTES*8
);
   logic                    ntr_valid;
   logic [DATA_W-1:0]       ntr_data;
   logic                    ntr_last;
   logic                    ntr_ready;
   logic                    dst_valid;
   logic [DATA_W-1:0]       dst_data;
   logic                    dst_last;
   logic                    dst_ready;
   logic                    tnif_valid;
   logic [DATA_W-1:0]       tnif_data;
   logic                    tnif_last;
   dfd_tn_pkg::tnifState_e  tnif_src;
   logic                    tnif_ready;

   // Arbiter side: consumes producer beats, drives the TNIF output.
   modport slave (
      input  ntr_valid, ntr_data, ntr_last,
      output ntr_ready,
      input  dst_valid, dst_data, dst_last,
      output dst_ready,
      output tnif_valid, tnif_data, tnif_last, tnif_src,
      input  tnif_ready
   );

   // Environment side: producers plus the downstream TNIF consumer.
   modport master (
      output ntr_valid, ntr_data, ntr_last,
      input  ntr_ready,
      output dst_valid, dst_data, dst_last,
      input  dst_ready,
      input  tnif_valid, tnif_data, tnif_last, tnif_src,
      output tnif_ready
   );
endinterface

// File: rtl/dfd_tnif_arb.sv
// Two-source message arbiter for the TNIF: whole-message grants, alternation on
// contention, single registered output stage and saturating per-source beat counters.
module dfd_tnif_arb
   import dfd_tn_pkg::*;
#(
   parameter int DATA_W = TNIF_DATA_OUT_WIDTH_IN_BYTES*8,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_ntr_en,
   input  logic              cfg_dst_en,
   dfd_tnif_arb_if.slave     tn,
   output tnifState_e        gnt_state,
   output logic              gnt_locked,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  ntr_beat_cnt,
   output logic [CNT_W-1:0]  dst_beat_cnt
);

   tnifState_e         gnt_state_q, gnt_state_d;
   logic               gnt_locked_q, gnt_locked_d;
   logic               tnif_valid_q, tnif_valid_d;
   logic [DATA_W-1:0]  tnif_data_q, tnif_data_d;
   logic               tnif_last_q, tnif_last_d;
   tnifState_e         tnif_src_q, tnif_src_d;
   logic [CNT_W-1:0]   ntr_cnt_q, ntr_cnt_d;
   logic [CNT_W-1:0]   dst_cnt_q, dst_cnt_d;

   logic               take;
   logic               ntr_cand, dst_cand;
   logic               grant_vld;
   tnifState_e         grant;
   logic               ntr_acc, dst_acc, acc_any, acc_last;
   logic [DATA_W-1:0]  acc_data;
   tnifState_e         acc_src;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // A locked message keeps its owner regardless of enables or the other source.
   always_comb begin
      take      = !tnif_valid_q || tn.tnif_ready;
      ntr_cand  = tn.ntr_valid && cfg_ntr_en;
      dst_cand  = tn.dst_valid && cfg_dst_en;
      grant_vld = 1'b0;
      grant     = NTR_GNT;
      if (gnt_locked_q) begin
         grant_vld = 1'b1;
         grant     = gnt_state_q;
      end else if (ntr_cand && dst_cand) begin
         grant_vld = 1'b1;
         grant     = (gnt_state_q == NTR_GNT) ? DST_GNT : NTR_GNT;
      end else if (ntr_cand) begin
         grant_vld = 1'b1;
         grant     = NTR_GNT;
      end else if (dst_cand) begin
         grant_vld = 1'b1;
         grant     = DST_GNT;
      end
   end

   assign tn.ntr_ready = reset_n && grant_vld && (grant == NTR_GNT) && take;
   assign tn.dst_ready = reset_n && grant_vld && (grant == DST_GNT) && take;

   assign ntr_acc  = tn.ntr_valid && tn.ntr_ready;
   assign dst_acc  = tn.dst_valid && tn.dst_ready;
   assign acc_any  = ntr_acc || dst_acc;
   assign acc_src  = dst_acc ? DST_GNT : NTR_GNT;
   assign acc_data = dst_acc ? tn.dst_data : tn.ntr_data;
   assign acc_last = dst_acc ? tn.dst_last : tn.ntr_last;

   always_comb begin
      gnt_state_d  = gnt_state_q;
      gnt_locked_d = gnt_locked_q;
      tnif_valid_d = tnif_valid_q;
      tnif_data_d  = tnif_data_q;
      tnif_last_d  = tnif_last_q;
      tnif_src_d   = tnif_src_q;
      if (acc_any) begin
         gnt_state_d  = acc_src;
         gnt_locked_d = !acc_last;
         tnif_valid_d = 1'b1;
         tnif_data_d  = acc_data;
         tnif_last_d  = acc_last;
         tnif_src_d   = acc_src;
      end else if (tn.tnif_ready) begin
         tnif_valid_d = 1'b0;
      end

      // Clear dominates a same-cycle increment.
      ntr_cnt_d = ntr_cnt_q;
      dst_cnt_d = dst_cnt_q;
      if (cnt_clr) begin
         ntr_cnt_d = '0;
         dst_cnt_d = '0;
      end else begin
         if (ntr_acc) ntr_cnt_d = sat_inc(ntr_cnt_q);
         if (dst_acc) dst_cnt_d = sat_inc(dst_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_state_q  <= DST_GNT;
         gnt_locked_q <= 1'b0;
         tnif_valid_q <= 1'b0;
         tnif_data_q  <= '0;
         tnif_last_q  <= 1'b0;
         tnif_src_q   <= NTR_GNT;
         ntr_cnt_q    <= '0;
         dst_cnt_q    <= '0;
      end else begin
         gnt_state_q  <= gnt_state_d;
         gnt_locked_q <= gnt_locked_d;
         tnif_valid_q <= tnif_valid_d;
         tnif_data_q  <= tnif_data_d;
         tnif_last_q  <= tnif_last_d;
         tnif_src_q   <= tnif_src_d;
         ntr_cnt_q    <= ntr_cnt_d;
         dst_cnt_q    <= dst_cnt_d;
      end
   end

   assign tn.tnif_valid  = tnif_valid_q;
   assign tn.tnif_data   = tnif_data_q;
   assign tn.tnif_last   = tnif_last_q;
   assign tn.tnif_src    = tnif_src_q;
   assign gnt_state      = gnt_state_q;
   assign gnt_locked     = gnt_locked_q;
   assign ntr_beat_cnt   = ntr_cnt_q;
   assign dst_beat_cnt   = dst_cnt_q;

endmodule

// File: tb/tb_dfd_tnif_arb.sv
// Bench for dfd_tnif_arb: reference model of the message arbitration rules, a
// vector table, directed corner-case sequences and a randomized run.
module tb_dfd_tnif_arb;
   import dfd_tn_pkg::*;

   localparam int DW   = 128;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cfg_ntr_en, cfg_dst_en, cnt_clr;
   tnifState_e    gnt_state;
   logic          gnt_locked;
   logic [CW-1:0] ntr_beat_cnt, dst_beat_cnt;

   dfd_tnif_arb_if #(.DATA_W(DW)) bus ();

   dfd_tnif_arb #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cfg_ntr_en   (cfg_ntr_en),
      .cfg_dst_en   (cfg_dst_en),
      .tn           (bus.slave),
      .gnt_state    (gnt_state),
      .gnt_locked   (gnt_locked),
      .cnt_clr      (cnt_clr),
      .ntr_beat_cnt (ntr_beat_cnt),
      .dst_beat_cnt (dst_beat_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: expected output register, owner, lock and counts.
   bit          m_valid;
   logic [DW-1:0] m_data;
   bit          m_last;
   int          m_src, m_gnt;
   bit          m_locked;
   int          m_ncnt, m_dcnt;

   int last_acc;
   bit last_nr, last_dr;

   typedef struct {
      bit nv, nl, dv, dl, ne, de, tr;
      bit enr, edr, elock;
   } vec_t;
   vec_t tbl[10];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_beat();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic m_reset();
      m_valid = 0; m_data = '0; m_last = 0; m_src = 0;
      m_gnt = 1; m_locked = 0; m_ncnt = 0; m_dcnt = 0;
   endtask

   // Who owns the output this cycle: -1 none, 0 NTR, 1 DST.
   function automatic int m_pick(input bit nc, input bit dc);
      if (m_locked) return m_gnt;
      if (nc && dc) return 1 - m_gnt;
      if (nc) return 0;
      if (dc) return 1;
      return -1;
   endfunction

   task automatic chk_out();
      chk1("tnif_valid", bus.tnif_valid, m_valid);
      if (m_valid) begin
         chkw("tnif_data", bus.tnif_data, m_data);
         chk1("tnif_last", bus.tnif_last, m_last);
         chki("tnif_src", int'(bus.tnif_src), m_src);
      end
      chki("gnt_state", int'(gnt_state), m_gnt);
      chk1("gnt_locked", gnt_locked, m_locked);
      chki("ntr_beat_cnt", int'(ntr_beat_cnt), m_ncnt);
      chki("dst_beat_cnt", int'(dst_beat_cnt), m_dcnt);
   endtask

   // Entered just after a falling edge; returns just after the next falling edge.
   task automatic step(input bit nv, nl, dv, dl, ne, de, tr, clr);
      int w, acc;
      logic [DW-1:0] nd, dd;
      nd = rnd_beat(); dd = rnd_beat();
      bus.ntr_valid = nv; bus.ntr_last = nl; bus.ntr_data = nd;
      bus.dst_valid = dv; bus.dst_last = dl; bus.dst_data = dd;
      cfg_ntr_en = ne; cfg_dst_en = de; bus.tnif_ready = tr; cnt_clr = clr;
      #1;
      w = (!m_valid || tr) ? m_pick(nv && ne, dv && de) : -1;
      last_nr = bus.ntr_ready; last_dr = bus.dst_ready;
      chk1("ntr_ready", bus.ntr_ready, w == 0);
      chk1("dst_ready", bus.dst_ready, w == 1);
      acc = -1;
      if (w == 0 && nv) acc = 0;
      if (w == 1 && dv) acc = 1;
      last_acc = acc;
      @(posedge clk);
      if (acc >= 0) begin
         m_valid = 1; m_data = (acc == 1) ? dd : nd; m_last = (acc == 1) ? dl : nl;
         m_src = acc; m_gnt = acc; m_locked = !m_last;
      end else if (tr) begin
         m_valid = 0;
      end
      if (clr) begin
         m_ncnt = 0; m_dcnt = 0;
      end else begin
         if (acc == 0 && m_ncnt < CMAX) m_ncnt++;
         if (acc == 1 && m_dcnt < CMAX) m_dcnt++;
      end
      @(negedge clk);
      chk_out();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.ntr_valid = 1; bus.dst_valid = 1; bus.ntr_last = 0; bus.dst_last = 0;
      bus.ntr_data = '0; bus.dst_data = '0;
      cfg_ntr_en = 1; cfg_dst_en = 1; bus.tnif_ready = 1; cnt_clr = 0;
      #1;
      chk1("rst_ntr_ready", bus.ntr_ready, 1'b0);
      chk1("rst_dst_ready", bus.dst_ready, 1'b0);
      bus.ntr_valid = 0; bus.dst_valid = 0;
      @(negedge clk);
      reset_n = 1'b1;
      m_reset();
      #1;
      chk_out();
      chkw("rst_tnif_data", bus.tnif_data, '0);
      chk1("rst_tnif_last", bus.tnif_last, 1'b0);
      chki("rst_tnif_src", int'(bus.tnif_src), int'(NTR_GNT));
   endtask

   initial begin
      reset_n = 1'b0;
      bus.ntr_valid = 0; bus.dst_valid = 0; bus.ntr_last = 0; bus.dst_last = 0;
      bus.ntr_data = '0; bus.dst_data = '0; bus.tnif_ready = 1;
      cfg_ntr_en = 1; cfg_dst_en = 1; cnt_clr = 0;
      m_reset();
      @(negedge clk);

      // nv nl dv dl ne de tr | ntr_ready dst_ready locked_after
      tbl[0] = '{1,0,0,0,1,1,1, 1,0,1};
      tbl[1] = '{1,1,1,1,1,1,1, 1,0,0};
      tbl[2] = '{1,1,1,1,1,1,1, 0,1,0};
      tbl[3] = '{1,1,1,1,1,1,1, 1,0,0};
      tbl[4] = '{0,0,1,0,1,0,1, 0,0,0};
      tbl[5] = '{0,0,1,0,1,1,1, 0,1,1};
      tbl[6] = '{1,1,1,1,1,1,0, 0,0,1};
      tbl[7] = '{1,1,1,1,1,1,1, 0,1,0};
      tbl[8] = '{1,1,0,0,0,1,1, 0,0,0};
      tbl[9] = '{0,0,0,0,1,1,1, 0,0,0};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].nv, tbl[i].nl, tbl[i].dv, tbl[i].dl, tbl[i].ne, tbl[i].de, tbl[i].tr, 1'b0);
         chk1("tbl_ntr_ready", last_nr, tbl[i].enr);
         chk1("tbl_dst_ready", last_dr, tbl[i].edr);
         chk1("tbl_locked", gnt_locked, tbl[i].elock);
      end

      // Single 4-beat NTR message.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, i == 3, 0, 0, 1, 1, 1, 0);
         chk1("single_valid", bus.tnif_valid, 1'b1);
         chki("single_src", int'(bus.tnif_src), int'(NTR_GNT));
         chk1("single_last", bus.tnif_last, i == 3);
         chk1("single_lock", gnt_locked, i != 3);
      end
      chki("single_cnt", int'(ntr_beat_cnt), 4);

      // Contention with back-to-back 2-beat messages from both sources.
      do_reset();
      begin
         bit nb, db;
         nb = 0; db = 0;
         for (int c = 0; c < 8; c++) begin
            step(1, nb, 1, db, 1, 1, 1, 0);
            if (last_acc == 0) nb = ~nb;
            else if (last_acc == 1) db = ~db;
            chk1("cont_valid", bus.tnif_valid, 1'b1);
            chki("cont_src", int'(bus.tnif_src), (c / 2) % 2);
         end
      end

      // Lock hold: DST keeps the message after its enable drops.
      do_reset();
      step(0, 0, 1, 0, 1, 1, 1, 0);
      step(1, 1, 1, 0, 1, 0, 1, 0);
      chk1("lock_b2_dst", last_dr, 1'b1);
      chk1("lock_b2_ntr", last_nr, 1'b0);
      step(1, 1, 1, 1, 1, 0, 1, 0);
      chk1("lock_b3_dst", last_dr, 1'b1);
      step(1, 0, 1, 0, 1, 0, 1, 0);
      chk1("lock_next_ntr", last_nr, 1'b1);
      chk1("lock_next_dst", last_dr, 1'b0);
      step(1, 1, 1, 0, 1, 0, 1, 0);
      step(0, 0, 1, 0, 1, 0, 1, 0);
      chk1("lock_dst_ignored", last_dr, 1'b0);

      // Backpressure mid-message.
      do_reset();
      step(1, 0, 0, 0, 1, 1, 1, 0);
      begin
         logic [DW-1:0] hold;
         hold = bus.tnif_data;
         for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 1, 1, 0, 0);
            chk1("bp_ntr_ready", last_nr, 1'b0);
            chk1("bp_dst_ready", last_dr, 1'b0);
            chkw("bp_data_hold", bus.tnif_data, hold);
         end
      end
      step(1, 1, 1, 0, 1, 1, 1, 0);
      chk1("bp_resume", last_nr, 1'b1);
      chki("bp_cnt", int'(ntr_beat_cnt), 2);

      // Counter saturation and clear-over-increment.
      do_reset();
      for (int i = 0; i < 17; i++) step(1, 1, 0, 0, 1, 1, 1, 0);
      chki("sat_cnt", int'(ntr_beat_cnt), CMAX);
      step(1, 1, 0, 0, 1, 1, 1, 1);
      chk1("clr_accept", last_nr, 1'b1);
      chki("clr_cnt", int'(ntr_beat_cnt), 0);
      step(1, 1, 0, 0, 1, 1, 1, 0);
      chki("clr_then_inc", int'(ntr_beat_cnt), 1);

      // Asynchronous reset in the middle of a DST message.
      do_reset();
      step(0, 0, 1, 0, 1, 1, 1, 0);
      bus.ntr_valid = 1; bus.dst_valid = 1;
      #2;
      reset_n = 1'b0;
      #1;
      m_reset();
      chk1("arst_valid", bus.tnif_valid, 1'b0);
      chk1("arst_lock", gnt_locked, 1'b0);
      chki("arst_gnt", int'(gnt_state), int'(DST_GNT));
      chk1("arst_ntr_ready", bus.ntr_ready, 1'b0);
      chk1("arst_dst_ready", bus.dst_ready, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      step(1, 1, 1, 1, 1, 1, 1, 0);
      chk1("arst_tie_ntr", last_nr, 1'b1);
      chki("arst_tie_src", int'(bus.tnif_src), int'(NTR_GNT));

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
